// File: rtl/counter_pkg.sv
// Shared types for the step counter: run modes, default width
// and the mode sequencing helper.
package counter_pkg;

   localparam int CNT_W_DEF = 3;

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'd0,
      MODE_AUTO   = 2'd1,
      MODE_PAUSE  = 2'd2
   } mode_e;

   // MANUAL -> AUTO -> PAUSE -> MANUAL; the unused code 2'd3 recovers to MANUAL.
   function automatic mode_e mode_next(input mode_e m);
      case (m)
         MODE_MANUAL: mode_next = MODE_AUTO;
         MODE_AUTO:   mode_next = MODE_PAUSE;
         default:     mode_next = MODE_MANUAL;
      endcase
   endfunction

endpackage

// File: rtl/step_ctrl_debouncer.sv
// Button conditioner: 2-flop synchronizer, stable-sample counter
// and a registered one-cycle press strobe on an accepted 0->1 level.
// Ports: clk, clrn (sync active-low), btn (raw, async), press (strobe out).
module step_ctrl_debouncer #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic clrn,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;

   always_ff @(posedge clk) begin
      if (!clrn) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   // Once DB_CYCLES differing samples have been counted the level is
   // accepted on the following edge, whatever that edge samples.
   always_comb begin
      sync_d  = {sync_q[0], btn};
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      if (cnt_q == CW'(DB_CYCLES)) begin
         level_d = ~level_q;
         cnt_d   = '0;
         press_d = ~level_q;
      end else if (sync_q[1] == level_q) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/step_ctrl.sv
// Next-state generator for the 3-bit count register: debounced STEP/MODE
// buttons, MANUAL/AUTO/PAUSE mode FSM, prescaled auto tick, ns = q+/-1 on step.
// Ports: clk, clrn, q (fed back), btn_step, btn_mode, sw_dir -> ns, mode, step.
module step_ctrl
   import counter_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int DB_CYCLES = 1_000_000,
   parameter int PRESCALE  = 50_000_000
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [CNT_W-1:0] q,
   input  logic             btn_step,
   input  logic             btn_mode,
   input  logic             sw_dir,
   output logic [CNT_W-1:0] ns,
   output logic [1:0]       mode,
   output logic             step
);

   localparam int PW = $clog2(PRESCALE);

   logic          step_press;
   logic          mode_press;
   mode_e         mode_q, mode_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          step_q, step_d;
   logic [1:0]    dir_sync_q, dir_sync_d;
   logic          tick;

   step_ctrl_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_step (
      .clk   (clk),
      .clrn  (clrn),
      .btn   (btn_step),
      .press (step_press)
   );

   step_ctrl_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
      .clk   (clk),
      .clrn  (clrn),
      .btn   (btn_mode),
      .press (mode_press)
   );

   always_ff @(posedge clk) begin
      if (!clrn) begin
         mode_q     <= MODE_MANUAL;
         presc_q    <= '0;
         step_q     <= 1'b0;
         dir_sync_q <= '0;
      end else begin
         mode_q     <= mode_d;
         presc_q    <= presc_d;
         step_q     <= step_d;
         dir_sync_q <= dir_sync_d;
      end
   end

   always_comb begin
      mode_d = mode_q;
      if (mode_press) begin
         mode_d = mode_next(mode_q);
      end
   end

   // Tick and step use the pre-transition mode, so a MODE press landing
   // on a tick still lets that tick through exactly once.
   always_comb begin
      tick       = (mode_q == MODE_AUTO) && (presc_q == PW'(PRESCALE - 1));
      step_d     = (step_press && (mode_q != MODE_AUTO)) || tick;
      dir_sync_d = {dir_sync_q[0], sw_dir};
      presc_d    = presc_q;
      if ((mode_d == MODE_AUTO) && (mode_q != MODE_AUTO)) begin
         presc_d = '0;
      end else if (mode_q == MODE_AUTO) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end
      ns = q;
      if (!clrn) begin
         ns = '0;
      end else if (step_q) begin
         ns = dir_sync_q[1] ? q + CNT_W'(1) : q - CNT_W'(1);
      end
   end

   assign mode = mode_q;
   assign step = step_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Randomized and directed bench for step_ctrl with an event-level
// reference model; q is looped back through a clrn register.
module tb_step_ctrl;

   localparam int DB = 4;
   localparam int PS = 10;
   localparam int N  = 8192;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       btn_step = 1'b0;
   logic       btn_mode = 1'b0;
   logic       sw_dir = 1'b0;
   logic [2:0] q;
   logic [2:0] ns;
   logic [1:0] mode;
   logic       step;
   logic       ld = 1'b0;
   logic [2:0] ld_v = '0;

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (!clrn) q <= '0;
      else if (ld) q <= ld_v;
      else q <= ns;
   end

   step_ctrl #(.CNT_W(3), .DB_CYCLES(DB), .PRESCALE(PS)) dut (
      .clk      (clk),
      .clrn     (clrn),
      .q        (q),
      .btn_step (btn_step),
      .btn_mode (btn_mode),
      .sw_dir   (sw_dir),
      .ns       (ns),
      .mode     (mode),
      .step     (step)
   );

   int checks = 0;
   int errors = 0;
   int stepcnt = 0;
   int n = 0;

   bit rs [N];
   bit rm [N];
   bit rd [N];
   bit rn [N];

   int m_lvl_s, m_lvl_m, m_lc_s, m_lc_m, m_pr_s, m_pr_m;
   int m_mode, m_ent, m_step, m_q;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, n, got, exp);
      end
   endtask

   // Value the second synchronizer flop presents at edge k.
   function automatic int samp(int id, int k);
      if (k < 2 || !rn[k-1] || !rn[k-2]) return 0;
      case (id)
         0: return int'(rs[k-2]);
         1: return int'(rm[k-2]);
         default: return int'(rd[k-2]);
      endcase
   endfunction

   // A new level is accepted at edge k when the DB samples before it,
   // all taken after the last change, differ from the current level.
   function automatic bit settled(int id, int lvl, int lc, int k);
      if (k - DB <= lc) return 1'b0;
      for (int j = 1; j <= DB; j++) begin
         if (samp(id, k - j) == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model(int k, bit ldk, int ldv);
      int os, om, ps, pm, d;
      if (!rn[k]) begin
         m_lvl_s = 0; m_lvl_m = 0;
         m_lc_s = k;  m_lc_m = k;
         m_pr_s = 0;  m_pr_m = 0;
         m_mode = 0;  m_step = 0; m_q = 0;
      end else begin
         os = m_step; om = m_mode; ps = m_pr_s; pm = m_pr_m;
         d = samp(2, k);
         if (ldk) m_q = ldv;
         else if (os != 0) m_q = (m_q + (d != 0 ? 1 : 7)) % 8;
         m_step = ((ps != 0 && om != 1) || (om == 1 && (k - m_ent) % PS == 0)) ? 1 : 0;
         if (pm != 0) begin
            m_mode = (om + 1) % 3;
            if (m_mode == 1) m_ent = k;
         end
         m_pr_s = 0;
         if (settled(0, m_lvl_s, m_lc_s, k)) begin
            m_lvl_s = 1 - m_lvl_s; m_lc_s = k; m_pr_s = m_lvl_s;
         end
         m_pr_m = 0;
         if (settled(1, m_lvl_m, m_lc_m, k)) begin
            m_lvl_m = 1 - m_lvl_m; m_lc_m = k; m_pr_m = m_lvl_m;
         end
      end
   endtask

   function automatic int exp_ns(int k);
      int dn;
      if (!rn[k]) return 0;
      dn = (k >= 1 && rn[k-1]) ? int'(rd[k-1]) : 0;
      if (m_step != 0) return (m_q + (dn != 0 ? 1 : 7)) % 8;
      return m_q;
   endfunction

   task automatic cyc();
      bit ldk;
      int ldv;
      if (n >= N) begin
         $display("FAIL cycle_budget: got %0d edges, limit %0d", n, N);
         $fatal(1);
      end
      @(posedge clk);
      rs[n] = btn_step; rm[n] = btn_mode;
      rd[n] = sw_dir;   rn[n] = clrn;
      ldk = ld; ldv = int'(ld_v);
      model(n, ldk, ldv);
      #1;
      chk("step", step, m_step);
      chk("mode", mode, m_mode);
      chk("q", q, m_q);
      chk("ns", ns, exp_ns(n));
      if (step) stepcnt++;
      n++;
   endtask

   task automatic cycles(int c);
      repeat (c) cyc();
   endtask

   task automatic press_btn(int id);
      if (id == 0) btn_step = 1'b1; else btn_mode = 1'b1;
      cycles(DB + 5);
      if (id == 0) btn_step = 1'b0; else btn_mode = 1'b0;
      cycles(DB + 5);
   endtask

   task automatic wait_mode(int want, string tag);
      for (int i = 0; i < 20 && mode != 2'(want); i++) cyc();
      chk(tag, mode, want);
   endtask

   initial begin
      int ent, qb;
      m_lc_s = 0; m_lc_m = 0; m_ent = 0;
      // 1: reset with both buttons held
      btn_step = 1'b1; btn_mode = 1'b1;
      cycles(2);
      clrn = 1'b1;
      cycles(7);
      chk("t1_early", step, 0);
      cyc();
      chk("t1_step", step, 1);
      chk("t1_mode", mode, 1);
      btn_step = 1'b0; btn_mode = 1'b0;
      cycles(10);
      press_btn(1);
      press_btn(1);
      chk("t2_manual", mode, 0);
      // 2: bouncy press from q=3, held high
      ld = 1'b1; ld_v = 3'd3; sw_dir = 1'b1;
      cyc();
      ld = 1'b0;
      cycles(3);
      stepcnt = 0;
      btn_step = 1'b1; cyc();
      btn_step = 1'b0; cyc();
      btn_step = 1'b1; cycles(15);
      chk("t2_steps", stepcnt, 1);
      chk("t2_q", q, 4);
      btn_step = 1'b0;
      cycles(10);
      // 3: wrap both ways
      ld = 1'b1; ld_v = 3'd7; cyc(); ld = 1'b0;
      press_btn(0);
      chk("t3_up_wrap", q, 0);
      sw_dir = 1'b0;
      cycles(3);
      press_btn(0);
      chk("t3_dn_wrap", q, 7);
      // 4: AUTO run, step button ignored
      sw_dir = 1'b1;
      btn_mode = 1'b1;
      wait_mode(1, "t4_auto");
      ent = n - 1;
      ld = 1'b1; ld_v = 3'd0; cyc();
      ld = 1'b0; btn_mode = 1'b0;
      cycles(5);
      btn_step = 1'b1; cycles(10);
      btn_step = 1'b0; cycles(15);
      chk("t4_q", q, 3);
      // 5: PAUSE holds, single step, back to MANUAL
      btn_mode = 1'b1;
      wait_mode(2, "t5_pause");
      btn_mode = 1'b0;
      stepcnt = 0;
      cycles(50);
      chk("t5_noticks", stepcnt, 0);
      qb = int'(q);
      press_btn(0);
      chk("t5_single", q, (qb + 1) % 8);
      press_btn(1);
      chk("t5_manual", mode, 0);
      // 6: MODE press landing on a tick
      btn_mode = 1'b1;
      wait_mode(1, "t6_auto");
      ent = n - 1;
      btn_mode = 1'b0;
      while (n < ent + 13) cyc();
      btn_mode = 1'b1;
      while (n <= ent + 20) cyc();
      chk("t6_step", step, 1);
      chk("t6_mode", mode, 2);
      btn_mode = 1'b0;
      stepcnt = 0;
      cycles(30);
      chk("t6_noticks", stepcnt, 0);
      // random traffic including short resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) btn_step = ~btn_step;
         if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(0, 19) == 0) sw_dir = ~sw_dir;
         clrn = ($urandom_range(0, 199) != 0);
         ld = ($urandom_range(0, 49) == 0);
         ld_v = 3'($urandom_range(0, 7));
         cyc();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
